matmul_mul_pipe_hs: RTL

//  Parametrised pipelined integer multiplier with valid/ready flow control for the matrix-multiplication datapath.

---
 rtl/matmul_mul_pkg.sv | 30 +++
 rtl/matmul_mul_stage.sv | 39 +++
 rtl/matmul_mul_pipe_hs.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/matmul_mul_pkg.sv
// matmul_mul_pkg
//   Shared definitions for the pipelined matrix-multiply multiplier.
//   - MODE_* : per-beat operand signedness ([0]=din0 signed, [1]=din1 signed)
//   - MAX_STAGE : deepest pipeline the multiplier is designed for
//   - MAX_TAG_WIDTH : widest sideband tag a beat can carry
//   - beat_t : control part of a pipeline beat (valid, mode, tag)
package matmul_mul_pkg;

  localparam logic [1:0] MODE_UU = 2'b00;
  localparam logic [1:0] MODE_SU = 2'b01;
  localparam logic [1:0] MODE_US = 2'b10;
  localparam logic [1:0] MODE_SS = 2'b11;

  localparam int MAX_STAGE     = 8;
  localparam int MAX_TAG_WIDTH = 64;

  // The tag field is sized for the widest supported tag; narrower tags are
  // zero-extended on entry and the unused upper bits fold away in synthesis.
  typedef struct packed {
    logic                     valid;
    logic [1:0]               mode;
    logic [MAX_TAG_WIDTH-1:0] tag;
  } beat_t;

  // True when the beat's result range is signed.
  function automatic logic mode_is_signed(input logic [1:0] mode);
    return mode != MODE_UU;
  endfunction

endpackage

// File: rtl/matmul_mul_stage.sv
// matmul_mul_stage
//   One pipeline register of the multiplier: product data plus beat control
//   (valid, mode, tag), loaded only when the pipeline advances.
//   Ports:
//     clk, reset_n      clock, asynchronous active-low reset
//     en_i              load enable (global pipeline advance)
//     data_i / data_o   product bits in / registered
//     beat_i / beat_o   beat control in / registered
module matmul_mul_stage
  import matmul_mul_pkg::*;
#(
  parameter int DATA_WIDTH = 63
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  beat_t                 beat_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output beat_t                 beat_o
);

  logic [DATA_WIDTH-1:0] data_q;
  beat_t                 beat_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
      beat_q <= '0;
    end else if (en_i) begin
      data_q <= data_i;
      beat_q <= beat_i;
    end
  end

  assign data_o = data_q;
  assign beat_o = beat_q;

endmodule

// File: rtl/matmul_mul_pipe_hs.sv
// matmul_mul_pipe_hs
//   Pipelined integer multiplier with valid/ready flow control. Each beat
//   carries its own signed/unsigned mode and a sideband tag returned with the
//   product. One product per cycle when the consumer is not stalling.
//   Optional feature macro: MUL_PIPE_SAT_EN (clamp to DOUT_WIDTH range and
//   sticky ovf flag); without it the product wraps and ovf is tied to 0.
//   Ports:
//     clk, reset_n                    clock, asynchronous active-low reset
//     in_valid / in_ready             operand beat handshake
//     din0, din1, in_mode, in_tag     operands, signedness, sideband tag
//     out_valid / out_ready           result handshake
//     dout, out_tag                   product and its tag
//     ovf                             sticky overflow (saturation builds)
module matmul_mul_pipe_hs
  import matmul_mul_pkg::*;
#(
  parameter int DIN0_WIDTH = 24,
  parameter int DIN1_WIDTH = 37,
  parameter int DOUT_WIDTH = 60,
  parameter int NUM_STAGE  = 2,
  parameter int TAG_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic [1:0]            in_mode,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  ovf
);

  localparam int PROD_WIDTH = DIN0_WIDTH + DIN1_WIDTH + 2;

  logic                  adv;
  logic [DIN0_WIDTH:0]   a_ext;
  logic [DIN1_WIDTH:0]   b_ext;
  logic [PROD_WIDTH-1:0] a_wide;
  logic [PROD_WIDTH-1:0] b_wide;
  beat_t                 in_beat;
  logic [PROD_WIDTH-1:0] stage_data [NUM_STAGE+1];
  beat_t                 stage_beat [NUM_STAGE+1];
  logic [PROD_WIDTH-1:0] prod_q;
  beat_t                 last_beat;

  // The whole pipeline moves together: it advances whenever the output slot
  // is empty or being drained this cycle.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // One extra bit per operand turns both into signed values, so a single
  // signed multiply covers all four modes.
  assign a_ext = {in_mode[0] & din0[DIN0_WIDTH-1], din0};
  assign b_ext = {in_mode[1] & din1[DIN1_WIDTH-1], din1};

  // Sign-extending to the full product width lets a plain modular multiply
  // yield the exact signed product (it always fits in PROD_WIDTH bits).
  assign a_wide = {{(PROD_WIDTH-DIN0_WIDTH-1){a_ext[DIN0_WIDTH]}}, a_ext};
  assign b_wide = {{(PROD_WIDTH-DIN1_WIDTH-1){b_ext[DIN1_WIDTH]}}, b_ext};

  always_comb begin
    in_beat       = '0;
    in_beat.valid = in_valid && adv;
    in_beat.mode  = in_mode;
    in_beat.tag   = MAX_TAG_WIDTH'(in_tag);
  end

  assign stage_data[0] = a_wide * b_wide;
  assign stage_beat[0] = in_beat;

  // Stage 0 registers the freshly computed product; the rest only retime it.
  generate
    for (genvar gi = 0; gi < NUM_STAGE; gi++) begin : g_stage
      matmul_mul_stage #(
        .DATA_WIDTH(PROD_WIDTH)
      ) u_stage (
        .clk    (clk),
        .reset_n(reset_n),
        .en_i   (adv),
        .data_i (stage_data[gi]),
        .beat_i (stage_beat[gi]),
        .data_o (stage_data[gi+1]),
        .beat_o (stage_beat[gi+1])
      );
    end
  endgenerate

  assign prod_q    = stage_data[NUM_STAGE];
  assign last_beat = stage_beat[NUM_STAGE];
  assign out_valid = last_beat.valid;
  assign out_tag   = last_beat.tag[TAG_WIDTH-1:0];

`ifdef MUL_PIPE_SAT_EN
  localparam logic [DOUT_WIDTH-1:0] SAT_SMIN = DOUT_WIDTH'(1) << (DOUT_WIDTH-1);
  localparam logic [DOUT_WIDTH-1:0] SAT_SMAX = ~SAT_SMIN;
  localparam logic [DOUT_WIDTH-1:0] SAT_UMAX = '1;

  logic signed_range;
  logic fits_signed;
  logic fits_unsigned;
  logic clamp;
  logic ovf_q;
  logic unused_bits;

  // A signed value fits when every bit from the result MSB upward is a copy
  // of the sign; an unsigned-mode product is never negative, so it fits when
  // nothing is set above the result width.
  assign signed_range  = mode_is_signed(last_beat.mode);
  assign fits_signed   = (&prod_q[PROD_WIDTH-1:DOUT_WIDTH-1]) ||
                         !(|prod_q[PROD_WIDTH-1:DOUT_WIDTH-1]);
  assign fits_unsigned = !(|prod_q[PROD_WIDTH-1:DOUT_WIDTH]);
  assign clamp         = signed_range ? !fits_signed : !fits_unsigned;

  always_comb begin
    dout = prod_q[DOUT_WIDTH-1:0];
    if (clamp) begin
      if (signed_range) dout = prod_q[PROD_WIDTH-1] ? SAT_SMIN : SAT_SMAX;
      else              dout = SAT_UMAX;
    end
  end

  // Flag only clamped results that actually leave the block.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
    end else if (out_valid && out_ready && clamp) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf         = ovf_q;
  assign unused_bits = ^last_beat.tag;
`else
  logic unused_bits;

  assign dout        = prod_q[DOUT_WIDTH-1:0];
  assign ovf         = 1'b0;
  assign unused_bits = ^{last_beat.tag, last_beat.mode, prod_q};
`endif

endmodule
